// File: rtl/xgpo_bank_pkg.sv
//------------------------------------------------------------------------------
// Module  : xgpo_bank_pkg
// Brief   : Register offsets, mode encodings and base address for xgpo_bank.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package xgpo_bank_pkg;

    localparam logic [1:0] XGPO_DATA   = 2'd0;
    localparam logic [1:0] XGPO_MODE   = 2'd1;
    localparam logic [1:0] XGPO_PERIOD = 2'd2;

    typedef enum logic [1:0] {
        XGPO_LEVEL  = 2'd0,
        XGPO_PULSE  = 2'd1,
        XGPO_TOGGLE = 2'd2,
        XGPO_BLINK  = 2'd3
    } xgpo_mode_e;

    // 64-byte aligned so the largest bank (16 channels, ADDR_W=6) fits the window.
    localparam logic [31:0] GPO_BASE = 32'h0000_0400;

endpackage

`default_nettype wire

// File: rtl/xgpo_chan.sv
//------------------------------------------------------------------------------
// Module  : xgpo_chan
// Brief   : One output channel: data/mode/period registers, counter, mode logic.
//           BLINK mode and the phase flop exist only with XGPO_BLINK_EN defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xgpo_chan
    import xgpo_bank_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int CNT_W          = 16,
    parameter int DEFAULT_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_data,
    input  logic             i_wr_mode,
    input  logic             i_wr_period,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_period,
    output logic [WIDTH-1:0] o_out,
    output logic [1:0]       o_mode,
    output logic [CNT_W-1:0] o_period
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_out;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_cnt;
    xgpo_mode_e       r_mode;
    xgpo_mode_e       w_mode;
    logic [CNT_W-1:0] w_load;

    assign w_load = (r_period == '0) ? CNT_W'(1) : r_period;

`ifdef XGPO_BLINK_EN
    logic r_phase;
    assign w_mode = r_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= 1'b1;
        end else if (i_wr_mode) begin
            r_phase <= 1'b1;
        end else if (!i_wr_data && (w_mode == XGPO_BLINK) && (r_cnt <= CNT_W'(1))) begin
            r_phase <= ~r_phase;
        end
    end
`else
    // MODE register keeps the written 3, but the channel runs it as LEVEL.
    assign w_mode = (r_mode == XGPO_BLINK) ? XGPO_LEVEL : r_mode;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_out    <= '0;
            r_cnt    <= '0;
            r_mode   <= XGPO_LEVEL;
            r_period <= CNT_W'(DEFAULT_PERIOD);
        end else begin
            if (i_wr_period) begin
                r_period <= i_period;
            end
            // A bus write on the same edge as a counter event takes priority.
            if (i_wr_mode) begin
                r_mode <= xgpo_mode_e'(i_mode);
                r_cnt  <= w_load;
                r_out  <= (i_mode == XGPO_PULSE) ? '0 : r_data;
            end else if (i_wr_data) begin
                r_data <= i_data;
                case (w_mode)
                    XGPO_PULSE: begin
                        r_out <= i_data;
                        r_cnt <= w_load;
                    end
                    XGPO_TOGGLE: r_out <= r_out ^ i_data;
`ifdef XGPO_BLINK_EN
                    XGPO_BLINK:  r_out <= r_phase ? i_data : '0;
`endif
                    default:     r_out <= i_data;
                endcase
            end else begin
                case (w_mode)
                    XGPO_PULSE: begin
                        if (r_cnt == CNT_W'(1)) begin
                            r_out <= '0;
                            r_cnt <= '0;
                        end else if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
`ifdef XGPO_BLINK_EN
                    XGPO_BLINK: begin
                        if (r_cnt <= CNT_W'(1)) begin
                            r_cnt <= w_load;
                            r_out <= r_phase ? '0 : r_data;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign o_out    = r_out;
    assign o_mode   = r_mode;
    assign o_period = r_period;

endmodule

`default_nettype wire

// File: rtl/xgpo_bank.sv
//------------------------------------------------------------------------------
// Module  : xgpo_bank
// Brief   : NCH-channel general-purpose output bank; channel decode and read mux.
//           Optional BLINK mode enabled by defining XGPO_BLINK_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xgpo_bank
    import xgpo_bank_pkg::*;
#(
    parameter int NCH            = 4,
    parameter int WIDTH          = 8,
    parameter int CNT_W          = 16,
    parameter int DEFAULT_PERIOD = 1000,
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = $clog2(NCH) + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data_in,
    output logic [DATA_W-1:0]    data_out,
    output logic [NCH*WIDTH-1:0] gpo_out
);

    logic [NCH-1:0]   w_hit;
    logic [1:0]       w_off;
    logic             w_wr;
    logic [WIDTH-1:0] w_rd_out  [NCH];
    logic [1:0]       w_rd_mode [NCH];
    logic [CNT_W-1:0] w_rd_per  [NCH];

    assign w_off = addr[1:0];
    assign w_wr  = sel & we;

    // Indices at or above NCH leave every w_hit bit clear, so they are inert.
    if (NCH == 1) begin : g_single
        assign w_hit = 1'b1;
    end else begin : g_multi
        for (genvar c = 0; c < NCH; c++) begin : g_hit
            assign w_hit[c] = (addr[ADDR_W-1:2] == (ADDR_W-2)'(c));
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        xgpo_chan #(
            .WIDTH          (WIDTH),
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_wr_data   (w_wr & w_hit[c] & (w_off == XGPO_DATA)),
            .i_wr_mode   (w_wr & w_hit[c] & (w_off == XGPO_MODE)),
            .i_wr_period (w_wr & w_hit[c] & (w_off == XGPO_PERIOD)),
            .i_data      (data_in[WIDTH-1:0]),
            .i_mode      (data_in[1:0]),
            .i_period    (data_in[CNT_W-1:0]),
            .o_out       (w_rd_out[c]),
            .o_mode      (w_rd_mode[c]),
            .o_period    (w_rd_per[c])
        );
        assign gpo_out[c*WIDTH +: WIDTH] = w_rd_out[c];
    end

    always_comb begin
        data_out = '0;
        if (sel && !we) begin
            for (int c = 0; c < NCH; c++) begin
                if (w_hit[c]) begin
                    case (w_off)
                        XGPO_DATA:   data_out = DATA_W'(w_rd_out[c]);
                        XGPO_MODE:   data_out = DATA_W'(w_rd_mode[c]);
                        XGPO_PERIOD: data_out = DATA_W'(w_rd_per[c]);
                        default:     data_out = '0;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xgpo_bank.sv
//------------------------------------------------------------------------------
// Module  : tb_xgpo_bank
// Brief   : Self-checking bench for xgpo_bank (NCH=4 main DUT, NCH=3 decode DUT).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_xgpo_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, we;
    logic [3:0]  addr;
    logic [15:0] data_in, data_out;
    logic [31:0] gpo_out;

    logic        sel2, we2;
    logic [3:0]  addr2;
    logic [15:0] data_in2, data_out2;
    logic [23:0] gpo_out2;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] gpo_q [$];
    logic [31:0] rd_q  [$];
    logic [7:0]  m_out [4];

    xgpo_bank u_dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .gpo_out  (gpo_out)
    );

    xgpo_bank #(.NCH(3)) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel2),
        .we       (we2),
        .addr     (addr2),
        .data_in  (data_in2),
        .data_out (data_out2),
        .gpo_out  (gpo_out2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_gpo();
        return {m_out[3], m_out[2], m_out[1], m_out[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int off, input logic [15:0] val);
        sel = 1'b1; we = 1'b1;
        addr = 4'((ch << 2) | off);
        data_in = val;
        tick();
        sel = 1'b0; we = 1'b0; data_in = '0;
    endtask

    task automatic rd_chk(input string tag, input int ch, input int off, input logic [31:0] exp);
        rd_q.push_back(exp);
        sel = 1'b1; we = 1'b0;
        addr = 4'((ch << 2) | off);
        #1;
        check(tag, {16'h0, data_out}, rd_q.pop_front());
        sel = 1'b0;
    endtask

    task automatic push_gpo(input int n);
        for (int i = 0; i < n; i++) gpo_q.push_back(model_gpo());
    endtask

    // Compares now, then once per following cycle until the queue drains.
    task automatic run_gpo(input string tag);
        check(tag, gpo_out, gpo_q.pop_front());
        while (gpo_q.size() > 0) begin
            tick();
            check(tag, gpo_out, gpo_q.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; data_in = '0;
        sel2 = 1'b0; we2 = 1'b0; addr2 = '0; data_in2 = '0;
        for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
        tick(); tick();
        rst = 1'b0;
        tick();

        check("reset_gpo", gpo_out, 32'h0);
        check("reset_dout", {16'h0, data_out}, 32'h0);
        for (int c = 0; c < 4; c++) begin
            rd_chk("reset_data",   c, 0, 32'd0);
            rd_chk("reset_mode",   c, 1, 32'd0);
            rd_chk("reset_period", c, 2, 32'd1000);
            rd_chk("reset_rsvd",   c, 3, 32'd0);
        end

        // LEVEL; upper data_in bits must be discarded
        wr(2, 0, 16'h7EA5);
        m_out[2] = 8'hA5; push_gpo(1); run_gpo("level");
        rd_chk("level_rd", 2, 0, 32'hA5);

        // PULSE of 5 cycles
        wr(0, 2, 16'd5);
        wr(0, 1, 16'd1);
        push_gpo(1); run_gpo("pulse_arm");
        wr(0, 0, 16'h00FF);
        m_out[0] = 8'hFF; push_gpo(5);
        m_out[0] = 8'h00; push_gpo(1);
        run_gpo("pulse");

        // Restart on the third cycle of a pulse
        wr(0, 0, 16'h00FF);
        m_out[0] = 8'hFF; push_gpo(3); run_gpo("pulse_pre");
        wr(0, 0, 16'h000F);
        m_out[0] = 8'h0F; push_gpo(5);
        m_out[0] = 8'h00; push_gpo(1);
        run_gpo("pulse_restart");

        // TOGGLE
        wr(1, 1, 16'd2);
        wr(1, 0, 16'h000F);
        m_out[1] = 8'h0F; push_gpo(1); run_gpo("toggle1");
        wr(1, 0, 16'h0003);
        m_out[1] = 8'h0C; push_gpo(1); run_gpo("toggle2");
        rd_chk("toggle_rd", 1, 0, 32'h0C);

        // BLINK (or steady level when the feature is absent)
        wr(3, 2, 16'd3);
        wr(3, 0, 16'h0081);
        m_out[3] = 8'h81; push_gpo(1); run_gpo("blink_pre");
        wr(3, 1, 16'd3);
        for (int i = 0; i < 12; i++) begin
`ifdef XGPO_BLINK_EN
            m_out[3] = (((i / 3) % 2) == 0) ? 8'h81 : 8'h00;
`else
            m_out[3] = 8'h81;
`endif
            push_gpo(1);
        end
        run_gpo("blink");
        rd_chk("blink_mode_rd", 3, 1, 32'd3);
        wr(3, 1, 16'd0);
        m_out[3] = 8'h81; push_gpo(1); run_gpo("blink_exit");

        // PERIOD=0 gives a one-cycle pulse; register still reads 0
        wr(0, 2, 16'd0);
        rd_chk("period0_rd", 0, 2, 32'd0);
        wr(0, 0, 16'h00AA);
        m_out[0] = 8'hAA; push_gpo(1);
        m_out[0] = 8'h00; push_gpo(1);
        run_gpo("pulse_p0");

        // Reserved offset: no state change
        wr(1, 3, 16'hFFFF);
        push_gpo(1); run_gpo("rsvd_wr");
        rd_chk("rsvd_rd",     1, 3, 32'd0);
        rd_chk("rsvd_data",   1, 0, 32'h0C);
        rd_chk("rsvd_mode",   1, 1, 32'd2);
        rd_chk("rsvd_period", 1, 2, 32'd1000);

        // Out-of-range channel on the 3-channel bank
        sel2 = 1'b1; we2 = 1'b1; addr2 = 4'b11_00; data_in2 = 16'h0055;
        tick();
        sel2 = 1'b0; we2 = 1'b0;
        check("oor_gpo", {8'h0, gpo_out2}, 32'h0);
        sel2 = 1'b1; addr2 = 4'b11_00; #1;
        check("oor_rd", {16'h0, data_out2}, 32'h0);
        sel2 = 1'b0;
        sel2 = 1'b1; we2 = 1'b1; addr2 = 4'b10_00; data_in2 = 16'h0012;
        tick();
        sel2 = 1'b0; we2 = 1'b0;
        check("inrange_gpo", {8'h0, gpo_out2}, 32'h0012_0000);
        sel2 = 1'b1; addr2 = 4'b10_00; #1;
        check("inrange_rd", {16'h0, data_out2}, 32'h12);
        sel2 = 1'b0;

        // Asynchronous reset in the middle of a pulse
        wr(0, 2, 16'd10);
        wr(0, 0, 16'h003C);
        m_out[0] = 8'h3C; push_gpo(3); run_gpo("pulse_long");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gpo", gpo_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        rd_chk("post_rst_period", 0, 2, 32'd1000);
        rd_chk("post_rst_data",   2, 0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
